// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array operand feeder and its test harness.
// Array size, element width, FSM state encoding and column-group boundaries.
package sa_pkg;

    localparam int SA_N      = 12;
    localparam int SA_DWIDTH = 64;

    // Column groups driven by enb_1 / enb_2_6 / enb_7_12 (zero-based column indices)
    localparam int SA_GRP1_LO = 0;
    localparam int SA_GRP1_HI = 0;
    localparam int SA_GRP2_LO = 1;
    localparam int SA_GRP2_HI = 5;
    localparam int SA_GRP3_LO = 6;
    localparam int SA_GRP3_HI = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        WAIT = 2'd3
    } sa_feed_state_t;

endpackage

// File: rtl/sa_col_enable_decode.sv
// Maps the number of active output columns to the three column-group enables.
// A group is enabled as soon as its lowest column falls inside the active range.
module sa_col_enable_decode
    import sa_pkg::*;
#(
    parameter int CW = $clog2(SA_N + 1)
) (
    input  logic [CW-1:0] cfg_cols,
    output logic          enb_1,
    output logic          enb_2_6,
    output logic          enb_7_12
);

    assign enb_1    = (cfg_cols > CW'(SA_GRP1_LO));
    assign enb_2_6  = (cfg_cols > CW'(SA_GRP2_LO));
    assign enb_7_12 = (cfg_cols > CW'(SA_GRP3_LO));

endmodule

// File: rtl/sa_operand_feeder.sv
// Systolic matmul front end: streams A then B into operand registers, runs the array,
// waits for cal_finish. Optional WAIT watchdog enabled by defining SA_FEEDER_WDOG_EN.
//
//  state | meaning
//  IDLE  | no job; start latches cfg_cols and clears err
//  LOAD  | s_ready high, beats fill a_row then b_col
//  RUN   | load_en held for RUN_CYCLES cycles
//  WAIT  | load_en still held, waiting for cal_finish (or watchdog)
module sa_operand_feeder
    import sa_pkg::*;
#(
    parameter int DWIDTH      = SA_DWIDTH,
    parameter int N           = SA_N,
    parameter int RUN_CYCLES  = 2 * N,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [$clog2(N+1)-1:0]             cfg_cols,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [DWIDTH-1:0]                  s_data,
    input  logic                               s_last,
    output logic [N-1:0][N-1:0][DWIDTH-1:0]    a_row,
    output logic [N-1:0][N-1:0][DWIDTH-1:0]    b_col,
    output logic                               load_en,
    output logic                               enb_1,
    output logic                               enb_2_6,
    output logic                               enb_7_12,
    input  logic                               cal_finish,
    output logic                               busy,
    output logic                               job_done,
    output logic                               err
);

    localparam int CW = $clog2(N + 1);
    localparam int IW = $clog2(N);
    localparam int RW = $clog2(RUN_CYCLES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [RW-1:0] RUN_LOAD = RW'(RUN_CYCLES - 1);

    sa_feed_state_t state_q, state_d;
    logic [CW-1:0]  cfg_q;
    logic [IW-1:0]  row_q, col_q;
    logic           phase_b_q;
    logic [RW-1:0]  run_cnt_q;
    logic           err_q, job_done_q, set_err;
    logic [2:0]     enb_q;
    logic           dec_1, dec_2_6, dec_7_12;
    logic           xfer, final_beat, run_next;

    assign s_ready    = (state_q == LOAD);
    assign busy       = (state_q != IDLE);
    assign load_en    = (state_q == RUN) || (state_q == WAIT);
    assign xfer       = s_valid && s_ready;
    assign final_beat = phase_b_q && (row_q == LAST_IDX) && (col_q == LAST_IDX);
    assign run_next   = (state_d == RUN) || (state_d == WAIT);
    assign {enb_1, enb_2_6, enb_7_12} = enb_q;
    assign err        = err_q;
    assign job_done   = job_done_q;

`ifdef SA_FEEDER_WDOG_EN
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WW-1:0] WD_LOAD = WW'(TIMEOUT_CYC - 1);
    logic [WW-1:0] wd_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q <= '0;
        end else if (state_d == WAIT && state_q != WAIT) begin
            wd_cnt_q <= WD_LOAD;
        end else if (state_q == WAIT && wd_cnt_q != '0) begin
            wd_cnt_q <= wd_cnt_q - 1'b1;
        end
    end
`endif

    sa_col_enable_decode #(.CW(CW)) u_col_dec (
        .cfg_cols (cfg_q),
        .enb_1    (dec_1),
        .enb_2_6  (dec_2_6),
        .enb_7_12 (dec_7_12)
    );

    always_comb begin
        state_d = state_q;
        set_err = 1'b0;
        case (state_q)
            IDLE: if (start) state_d = LOAD;
            LOAD: begin
                if (xfer) begin
                    // an early s_last and a missing final s_last are both framing errors
                    if (s_last != final_beat) begin
                        set_err = 1'b1;
                        state_d = IDLE;
                    end else if (final_beat) begin
                        state_d = RUN;
                    end
                end
            end
            RUN:  if (run_cnt_q == '0) state_d = WAIT;
            WAIT: begin
                if (cal_finish) begin
                    state_d = IDLE;
`ifdef SA_FEEDER_WDOG_EN
                end else if (wd_cnt_q == '0) begin
                    set_err = 1'b1;
                    state_d = IDLE;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cfg_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            phase_b_q  <= 1'b0;
            run_cnt_q  <= '0;
            err_q      <= 1'b0;
            job_done_q <= 1'b0;
            enb_q      <= '0;
        end else begin
            state_q    <= state_d;
            job_done_q <= (state_q == WAIT) && cal_finish;
            enb_q      <= run_next ? {dec_1, dec_2_6, dec_7_12} : 3'b000;

            if (state_q == IDLE && start) begin
                cfg_q     <= (cfg_cols > CW'(N)) ? CW'(N) : cfg_cols;
                row_q     <= '0;
                col_q     <= '0;
                phase_b_q <= 1'b0;
                err_q     <= 1'b0;
            end else if (set_err) begin
                err_q <= 1'b1;
            end

            if (state_q == LOAD && xfer) begin
                if (col_q == LAST_IDX) begin
                    col_q <= '0;
                    if (row_q == LAST_IDX) begin
                        row_q     <= '0;
                        phase_b_q <= 1'b1;
                    end else begin
                        row_q <= row_q + 1'b1;
                    end
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end

            if (state_d == RUN && state_q != RUN) begin
                run_cnt_q <= RUN_LOAD;
            end else if (state_q == RUN && run_cnt_q != '0) begin
                run_cnt_q <= run_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_row <= '0;
            b_col <= '0;
        end else if (state_q == LOAD && xfer) begin
            if (!phase_b_q) a_row[row_q][col_q] <= s_data;
            else            b_col[row_q][col_q] <= s_data;
        end
    end

endmodule

// File: tb/tb_sa_operand_feeder.sv
// Scoreboard bench for sa_operand_feeder: stimulus pushes expected events, a negedge
// monitor pops them on load_en rise, job_done and err rise. Watchdog job under SA_FEEDER_WDOG_EN.
module tb_sa_operand_feeder;
    import sa_pkg::*;

    localparam int N     = SA_N;
    localparam int DW    = SA_DWIDTH;
    localparam int NN    = N * N;
    localparam int BEATS = 2 * NN;
    localparam int RUNC  = 2 * N;
    localparam int IW    = $clog2(N);
    localparam int CW    = $clog2(N + 1);

    typedef logic [N-1:0][N-1:0][DW-1:0] mat_t;
    typedef enum int {EV_RUN, EV_DONE, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [2:0] enb;
        int         len;
        mat_t       a;
        mat_t       b;
    } ev_t;

    logic          clk, rst_n, start, s_valid, s_ready, s_last;
    logic [CW-1:0] cfg_cols;
    logic [DW-1:0] s_data;
    mat_t          a_row, b_col;
    logic          load_en, enb_1, enb_2_6, enb_7_12, cal_finish, busy, job_done, err;

    sa_operand_feeder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_cols(cfg_cols),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .a_row(a_row), .b_col(b_col), .load_en(load_en),
        .enb_1(enb_1), .enb_2_6(enb_2_6), .enb_7_12(enb_7_12),
        .cal_finish(cal_finish), .busy(busy), .job_done(job_done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    ev_t  sb_q[$];
    mat_t mdl_a = '0;
    mat_t mdl_b = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_mat(input string name, input mat_t act, input mat_t exp);
        bit found = 1'b0;
        checks++;
        if (act !== exp) begin
            failures++;
            for (int i = 0; i < N; i++)
                for (int k = 0; k < N; k++)
                    if (!found && act[IW'(i)][IW'(k)] !== exp[IW'(i)][IW'(k)]) begin
                        found = 1'b1;
                        $display("FAIL %s at [%0d][%0d] actual=%0h expected=%0h", name, i, k,
                                 act[IW'(i)][IW'(k)], exp[IW'(i)][IW'(k)]);
                    end
        end
    endtask

    // monitor
    ev_t mon_e;
    bit  prev_load = 1'b0, prev_err = 1'b0, prev_done = 1'b0;
    int  run_len = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (load_en && !prev_load) begin
                run_len = 0;
                if (sb_q.size() == 0) chk("unexpected_load_en", 64'(load_en), 64'(0));
                else begin
                    mon_e = sb_q.pop_front();
                    chk("ev_kind_run", 64'(int'(EV_RUN)), 64'(int'(mon_e.kind)));
                    chk("enb_at_load_en", 64'({enb_1, enb_2_6, enb_7_12}), 64'(mon_e.enb));
                end
            end
            if (load_en) run_len++;
            if (job_done) begin
                chk("job_done_width", 64'(prev_done), 64'(0));
                if (sb_q.size() == 0) chk("unexpected_job_done", 64'(job_done), 64'(0));
                else begin
                    mon_e = sb_q.pop_front();
                    chk("ev_kind_done", 64'(int'(EV_DONE)), 64'(int'(mon_e.kind)));
                    chk("load_en_cycles", 64'(run_len), 64'(mon_e.len));
                    chk_mat("a_row", a_row, mon_e.a);
                    chk_mat("b_col", b_col, mon_e.b);
                end
            end
            if (err && !prev_err) begin
                if (sb_q.size() == 0) chk("unexpected_err", 64'(err), 64'(0));
                else begin
                    mon_e = sb_q.pop_front();
                    chk("ev_kind_err", 64'(int'(EV_ERR)), 64'(int'(mon_e.kind)));
                    if (mon_e.len >= 0) chk("load_en_cycles_to_err", 64'(run_len), 64'(mon_e.len));
                    chk_mat("a_row_on_err", a_row, mon_e.a);
                    chk_mat("b_col_on_err", b_col, mon_e.b);
                end
            end
        end
        prev_load = load_en;
        prev_err  = err;
        prev_done = job_done;
    end

    function automatic logic [DW-1:0] pat(input int mode, input int b);
        if (mode == 0) begin
            if (b < NN) return (b / N == b % N) ? 64'd1 : 64'd0;
            return 64'(b - NN);
        end
        return {16'hC0DE, 16'(mode), 32'(b)};
    endfunction

    task automatic do_start(input int cfg);
        start    = 1'b1;
        cfg_cols = CW'(cfg);
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 64'(busy), 64'(1));
        chk("start_err_clear", 64'(err), 64'(0));
    endtask

    // cal_d: cycles after load_en rises before cal_finish (-1 = never)
    task automatic run_job(input int cfg, input int mode, input bit gaps, input int bad_at,
                           input bit drop_last, input int cal_d, input int ld_start_at,
                           input bit wait_start, input logic [2:0] exp_enb, input int rst_at);
        ev_t e;
        int  n;
        bit  stop = 1'b0;
        bit  err_job = 1'b0;
        e.enb = 3'b000;
        e.len = -1;
        if (!gaps) begin
            s_valid = 1'b1;
            s_data  = pat(mode, 0);
            s_last  = 1'b0;
        end
        do_start(cfg);
        for (int b = 0; b < BEATS && !stop; b++) begin
            if (gaps) begin
                s_valid = 1'b0;
                while ($urandom_range(1) == 1) @(negedge clk);
            end
            s_valid = 1'b1;
            s_data  = pat(mode, b);
            s_last  = (b == bad_at) || (b == BEATS - 1 && !drop_last);
            start   = (b == ld_start_at);
            n = 0;
            while (!s_ready && n < 20) begin @(negedge clk); n++; end
            if (!s_ready) begin
                chk("s_ready_timeout", 64'(s_ready), 64'(1));
                stop = 1'b1;
            end else begin
                if (b < NN) mdl_a[IW'(b / N)][IW'(b % N)] = s_data;
                else        mdl_b[IW'((b - NN) / N)][IW'((b - NN) % N)] = s_data;
                e.a = mdl_a;
                e.b = mdl_b;
                if (b == bad_at || (b == BEATS - 1 && drop_last)) begin
                    e.kind = EV_ERR; e.len = -1; sb_q.push_back(e);
                    err_job = 1'b1; stop = 1'b1;
                end else if (b == BEATS - 1) begin
                    e.kind = EV_RUN; e.enb = exp_enb; sb_q.push_back(e);
                    if (cal_d < 0) begin
                        e.kind = EV_ERR; e.len = RUNC + 256; sb_q.push_back(e);
                    end else if (rst_at < 0) begin
                        e.kind = EV_DONE; e.len = (cal_d < RUNC) ? RUNC + 1 : cal_d + 1;
                        sb_q.push_back(e);
                    end
                end
                @(negedge clk);
                start = 1'b0;
            end
        end
        s_valid = 1'b0; s_last = 1'b0; start = 1'b0;
        if (err_job) begin
            chk("err_next_cycle", 64'(err), 64'(1));
            chk("err_idle", 64'(busy), 64'(0));
            chk("err_no_load_en", 64'(load_en), 64'(0));
            repeat (4) @(negedge clk);
            return;
        end
        if (stop) return;
        n = 0;
        while (!load_en && n < 5) begin @(negedge clk); n++; end
        chk("load_en_rise", 64'(load_en), 64'(1));
        if (!load_en) return;
        if (rst_at >= 0) begin
            repeat (rst_at) @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            chk("rst_load_en", 64'(load_en), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_s_ready", 64'(s_ready), 64'(0));
            chk("rst_enb", 64'({enb_1, enb_2_6, enb_7_12}), 64'(0));
            mdl_a = '0;
            mdl_b = '0;
            @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            chk("post_rst_idle", 64'(busy), 64'(0));
            chk_mat("post_rst_a_row", a_row, mdl_a);
            return;
        end
        if (cal_d >= 0) begin
            for (int k = 0; k < cal_d; k++) begin
                start = wait_start && (k == 30);
                @(negedge clk);
                start = 1'b0;
                if (wait_start && k == 30) chk("wait_start_ignored", 64'(busy && load_en), 64'(1));
            end
            cal_finish = 1'b1;
        end
        n = 0;
        while (busy && n < RUNC + 300) begin @(negedge clk); n++; end
        chk("job_returns_idle", 64'(busy), 64'(0));
        cal_finish = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_cols = '0; s_valid = 1'b0; s_data = '0;
        s_last = 1'b0; cal_finish = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_s_ready", 64'(s_ready), 64'(0));
        chk("reset_load_en", 64'(load_en), 64'(0));
        chk("reset_enb", 64'({enb_1, enb_2_6, enb_7_12}), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_job_done", 64'(job_done), 64'(0));
        chk("reset_err", 64'(err), 64'(0));
        chk_mat("reset_a_row", a_row, '0);
        chk_mat("reset_b_col", b_col, '0);
        rst_n = 1'b1;
        @(negedge clk);

        run_job(12, 0, 1'b0, -1, 1'b0, 0,  -1, 1'b0, 3'b111, -1);  // A=I, B=k*N+j
        run_job(6,  1, 1'b1, -1, 1'b0, 30, -1, 1'b0, 3'b110, -1);  // random gaps
        run_job(12, 2, 1'b0, 100, 1'b0, 0, -1, 1'b0, 3'b000, -1);  // early s_last
        run_job(7,  3, 1'b0, -1, 1'b0, 40, 50, 1'b1, 3'b111, -1);  // start in LOAD and WAIT
        run_job(0,  4, 1'b0, -1, 1'b0, 5,  -1, 1'b0, 3'b000, -1);
        run_job(15, 5, 1'b0, -1, 1'b0, 24, -1, 1'b0, 3'b111, -1);  // saturates to N
        run_job(1,  6, 1'b0, -1, 1'b0, 3,  -1, 1'b0, 3'b100, -1);
        run_job(2,  7, 1'b0, -1, 1'b1, 0,  -1, 1'b0, 3'b000, -1);  // missing final s_last
        run_job(12, 8, 1'b0, -1, 1'b0, 0,  -1, 1'b0, 3'b111, 5);   // reset in RUN
`ifdef SA_FEEDER_WDOG_EN
        run_job(12, 9, 1'b0, -1, 1'b0, -1, -1, 1'b0, 3'b111, -1);
        chk("wdog_err", 64'(err), 64'(1));
`endif
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
